satd_hadamard_acc: RTL and testbench
====================================

SATD_HADAMARD_ACC -- requirements
Module: satd_hadamard_acc

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset; synchronous, active-high, sampled on the rising edge of clk.
REQ-003 in_valid  input  1  a row of 8 differences is presented this cycle.
REQ-004 in_first  input  1  qualified by in_valid; the presented row is row 0 of a new 8x8 block.
REQ-005 diff_0..diff_7  input  9 each  signed two's-complement differences, column c = index c.
REQ-006 satd  output  20  unsigned sum of absolute 2D Hadamard coefficients of the last complete block.
REQ-007 satd_valid  output  1  one-cycle pulse; satd is new this cycle.
REQ-008 row_idx  output  3  index the next accepted row will take (0..7).
REQ-009 drain_busy  output  1  the drain stage is summing a captured block.
REQ-010 partial_drop  output  1  one-cycle pulse; a partially filled block was discarded.

Function
REQ-011 The block SHALL never back-pressure and SHALL accept one row on every clock where in_valid=1, including back-to-back blocks.
REQ-012 Horizontal stage (combinational, same cycle): h_k = sum over c of (-1)^popcount(k&c) * diff_c, for k=0..7, 12-bit signed, no saturation.
REQ-013 Vertical stage: 64 accumulators acc[k][c], 15-bit signed; accepting row r SHALL add (-1)^popcount(k&r) * h_c to acc[k][c].
REQ-014 When row 0 is accepted, accumulators SHALL be loaded with the row-0 contribution, not added to prior contents.
REQ-015 row_idx SHALL increment by 1 per accepted row, wrap 7->0, and hold when in_valid=0.
REQ-016 in_valid=1 with in_first=1 SHALL force the row to index 0.
REQ-017 If row_idx was nonzero in that case, partial_drop SHALL pulse in the next cycle and the partial block SHALL be discarded.
REQ-018 On the edge accepting row 7, the final 64 coefficients (accumulator plus row-7 contribution) SHALL be copied into a drain bank.
REQ-019 That same edge SHALL set drain_busy=1 and clear the drain count and running sum.
REQ-020 Drain: on each of the next 8 edges, running sum SHALL add sum over c of |bank[k][c]| for k = drain count 0..7, 20-bit unsigned.
REQ-021 On the 8th drain edge (8 edges after the edge accepting row 7), satd SHALL load the final sum, satd_valid SHALL pulse for one cycle and drain_busy SHALL fall.
REQ-022 satd SHALL hold its value until the next satd_valid.
REQ-023 Because a block needs at least 8 row cycles, drain SHALL always finish before the next block's row 7; the drain bank SHALL not be overwritten while draining.
REQ-024 The reported value is the raw sum, with no normalisation or rounding.
REQ-025 Worst case 64*16320 = 1,044,480 fits 20 bits; no overflow handling is required.
REQ-026 States: FILL (row_idx 0..7, always active) in parallel with DRAIN_IDLE / DRAIN_RUN(0..7).
REQ-027 DRAIN_RUN is entered only from the row-7 accept and SHALL return to DRAIN_IDLE after step 7.

Reset
REQ-028 While rst=1 on an edge, row_idx, accumulators, drain bank, drain count, running sum and satd SHALL become 0.
REQ-029 While rst=1 on an edge, satd_valid, drain_busy and partial_drop SHALL become 0.
REQ-030 rst SHALL take priority over in_valid on the same edge; the row presented is dropped.
REQ-031 Reset during DRAIN_RUN SHALL abort the drain and SHALL produce no satd_valid for that block.

Verification
REQ-032 8 rows all diffs=+1, in_first on row 0 -> single satd_valid 8 cycles after row 7, satd=64.
REQ-033 8 rows all diffs=+255, then 8 rows all diffs=-255, back-to-back -> two satd_valid pulses 8 cycles apart, each satd=16320.
REQ-034 Row 0 with diff_0=1 and all other diffs/rows 0 -> satd=64 (every coefficient ±1).
REQ-035 3 rows then in_first=1 with 8 rows of +1 -> partial_drop pulse once, then satd=64, row_idx back to 0.
REQ-036 in_valid gaps of 1-3 cycles inside a block of +1 rows -> satd=64, latency measured from row 7 stays 8 edges.
REQ-037 rst asserted at drain step 4 -> no satd_valid, satd=0, drain_busy=0; a following clean block gives the correct satd.

Source files
------------

// File: rtl/satd_hadamard_acc.sv
// SATD of 8x8 blocks: a row-wise Hadamard is followed by a column-wise Hadamard accumulated in 64 registers.
// Latency: satd_valid pulses 8 clock edges after the edge that accepts row 7.
// Backpressure: none; the block accepts one row on every cycle that in_valid is high.
module satd_hadamard_acc (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_first,
   input  logic signed [8:0] diff_0,
   input  logic signed [8:0] diff_1,
   input  logic signed [8:0] diff_2,
   input  logic signed [8:0] diff_3,
   input  logic signed [8:0] diff_4,
   input  logic signed [8:0] diff_5,
   input  logic signed [8:0] diff_6,
   input  logic signed [8:0] diff_7,
   output logic [19:0]       satd,
   output logic              satd_valid,
   output logic [2:0]        row_idx,
   output logic              drain_busy,
   output logic              partial_drop
);

   typedef enum logic {DRAIN_IDLE, DRAIN_RUN} drain_state_t;

   // Hadamard sign: the entry at (a, b) is negative when popcount(a & b) is odd.
   function automatic logic hneg(input logic [2:0] a, input logic [2:0] b);
      return ^(a & b);
   endfunction

   logic signed [8:0]  diff [8];
   logic signed [11:0] h [8];
   logic signed [14:0] acc_q [8][8];
   logic signed [14:0] acc_nx [8][8];
   logic signed [14:0] bank_q [8][8];
   logic [2:0]         row_idx_q;
   logic [2:0]         row_eff;
   logic               row7_acc;
   logic               partial_drop_q;

   drain_state_t       drain_state_q, drain_state_d;
   logic [2:0]         drain_cnt_q, drain_cnt_d;
   logic [19:0]        sum_q, sum_d;
   logic [19:0]        satd_q, satd_d;
   logic               satd_valid_q, satd_valid_d;
   logic [19:0]        row_abs;

   assign diff[0] = diff_0;
   assign diff[1] = diff_1;
   assign diff[2] = diff_2;
   assign diff[3] = diff_3;
   assign diff[4] = diff_4;
   assign diff[5] = diff_5;
   assign diff[6] = diff_6;
   assign diff[7] = diff_7;

   // An in_first row always restarts the block at row 0.
   assign row_eff  = (in_valid && in_first) ? 3'd0 : row_idx_q;
   assign row7_acc = in_valid && (row_eff == 3'd7);

   // Horizontal 8-point Hadamard of the incoming row; 12-bit wrap is the intended width.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         h[k] = '0;
         for (int c = 0; c < 8; c++) begin
            if (hneg(3'(k), 3'(c)))
               h[k] = h[k] - {{3{diff[c][8]}}, diff[c]};
            else
               h[k] = h[k] + {{3{diff[c][8]}}, diff[c]};
         end
      end
   end

   // Vertical stage: row 0 loads fresh, later rows add their signed contribution.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 8; c++) begin
            acc_nx[k][c] = (row_eff == 3'd0) ? 15'sd0 : acc_q[k][c];
            if (hneg(3'(k), row_eff))
               acc_nx[k][c] = acc_nx[k][c] - {{3{h[c][11]}}, h[c]};
            else
               acc_nx[k][c] = acc_nx[k][c] + {{3{h[c][11]}}, h[c]};
         end
      end
   end

   // Row counter, accumulators, drain bank capture and partial-block detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx_q      <= 3'd0;
         partial_drop_q <= 1'b0;
         for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 8; c++) begin
               acc_q[k][c]  <= '0;
               bank_q[k][c] <= '0;
            end
         end
      end else begin
         partial_drop_q <= in_valid && in_first && (row_idx_q != 3'd0);
         if (in_valid) begin
            row_idx_q <= row_eff + 3'd1;
            for (int k = 0; k < 8; k++) begin
               for (int c = 0; c < 8; c++) begin
                  acc_q[k][c] <= acc_nx[k][c];
                  if (row7_acc)
                     bank_q[k][c] <= acc_nx[k][c];
               end
            end
         end
      end
   end

   // Sum of magnitudes of the bank row selected by the drain count.
   always_comb begin
      row_abs = '0;
      for (int c = 0; c < 8; c++) begin
         row_abs = row_abs + {5'd0, (bank_q[drain_cnt_q][c][14] ?
                                     (15'd0 - bank_q[drain_cnt_q][c]) :
                                     bank_q[drain_cnt_q][c])};
      end
   end

   // Drain FSM next state: eight summing steps, then publish; a row-7 accept (re)starts it.
   always_comb begin
      drain_state_d = drain_state_q;
      drain_cnt_d   = drain_cnt_q;
      sum_d         = sum_q;
      satd_d        = satd_q;
      satd_valid_d  = 1'b0;
      case (drain_state_q)
         DRAIN_RUN: begin
            sum_d       = sum_q + row_abs;
            drain_cnt_d = drain_cnt_q + 3'd1;
            if (drain_cnt_q == 3'd7) begin
               satd_d        = sum_q + row_abs;
               satd_valid_d  = 1'b1;
               drain_state_d = DRAIN_IDLE;
            end
         end
         default: ;
      endcase
      // The final drain step reads the old bank on the same edge a new row 7 overwrites it.
      if (row7_acc) begin
         drain_state_d = DRAIN_RUN;
         drain_cnt_d   = 3'd0;
         sum_d         = '0;
      end
   end

   // Drain FSM state register; reset aborts any drain in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_state_q <= DRAIN_IDLE;
         drain_cnt_q   <= 3'd0;
         sum_q         <= '0;
         satd_q        <= '0;
         satd_valid_q  <= 1'b0;
      end else begin
         drain_state_q <= drain_state_d;
         drain_cnt_q   <= drain_cnt_d;
         sum_q         <= sum_d;
         satd_q        <= satd_d;
         satd_valid_q  <= satd_valid_d;
      end
   end

   assign satd         = satd_q;
   assign satd_valid   = satd_valid_q;
   assign row_idx      = row_idx_q;
   assign drain_busy   = (drain_state_q == DRAIN_RUN);
   assign partial_drop = partial_drop_q;

endmodule

// File: tb/tb_satd_hadamard_acc.sv
// Bench for satd_hadamard_acc: directed block scenarios plus random traffic.
// A block-level model (full 2D Hadamard on a stored 8x8 matrix) predicts every output each cycle.
// Inputs change only after the compare point, which is 1 time unit after the rising edge.
module tb_satd_hadamard_acc;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_first;
   logic signed [8:0] d [8];
   logic [19:0]       satd;
   logic              satd_valid;
   logic [2:0]        row_idx;
   logic              drain_busy;
   logic              partial_drop;

   always #5 clk = ~clk;

   satd_hadamard_acc dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_first     (in_first),
      .diff_0       (d[0]),
      .diff_1       (d[1]),
      .diff_2       (d[2]),
      .diff_3       (d[3]),
      .diff_4       (d[4]),
      .diff_5       (d[5]),
      .diff_6       (d[6]),
      .diff_7       (d[7]),
      .satd         (satd),
      .satd_valid   (satd_valid),
      .row_idx      (row_idx),
      .drain_busy   (drain_busy),
      .partial_drop (partial_drop)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   // Model state
   int blk [8][8];
   int m_row = 0;
   int m_rem = 0;
   int m_pend = 0;
   int m_satd = 0;
   bit m_sv = 1'b0;
   bit m_pd = 1'b0;
   int m_r7cyc = 0;
   int m_r7_prev = 0;

   // Observed-pulse bookkeeping for the literal checks
   int n_pulse, n_pd, last_val, last_lat, first_val, first_cyc, last_cyc;

   function automatic int hs(input int a, input int b);
      return ($countones(a & b) % 2) ? -1 : 1;
   endfunction

   // Straight matrix form: T = H * D * H', SATD = sum |T|.
   function automatic int satd_of();
      int s = 0;
      for (int k = 0; k < 8; k++) begin
         for (int c = 0; c < 8; c++) begin
            int t = 0;
            for (int r = 0; r < 8; r++)
               for (int j = 0; j < 8; j++)
                  t += hs(k, r) * hs(c, j) * blk[r][j];
            s += (t < 0) ? -t : t;
         end
      end
      return s;
   endfunction

   task automatic model_step();
      m_sv      = 1'b0;
      m_pd      = 1'b0;
      m_r7_prev = m_r7cyc;
      if (rst) begin
         m_row  = 0;
         m_rem  = 0;
         m_satd = 0;
      end else begin
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_satd = m_pend;
               m_sv   = 1'b1;
            end
         end
         if (in_valid) begin
            if (in_first) begin
               if (m_row != 0) m_pd = 1'b1;
               m_row = 0;
            end
            for (int j = 0; j < 8; j++) blk[m_row][j] = d[j];
            if (m_row == 7) begin
               m_pend  = satd_of();
               m_rem   = 8;
               m_r7cyc = cyc;
            end
            m_row = (m_row + 1) % 8;
         end
      end
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp)
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      else
         n_pass++;
   endtask

   task automatic compare();
      check("satd",         32'(satd),         32'(m_satd));
      check("satd_valid",   32'(satd_valid),   32'(m_sv));
      check("row_idx",      32'(row_idx),      32'(m_row));
      check("drain_busy",   32'(drain_busy),   32'(m_rem > 0));
      check("partial_drop", 32'(partial_drop), 32'(m_pd));
      if (satd_valid === 1'b1) begin
         n_pulse++;
         last_val = int'(satd);
         last_lat = cyc - m_r7_prev;
         last_cyc = cyc;
         if (n_pulse == 1) begin
            first_val = int'(satd);
            first_cyc = cyc;
         end
      end
      if (partial_drop === 1'b1) n_pd++;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      compare();
   endtask

   task automatic set_all(input int val);
      for (int j = 0; j < 8; j++) d[j] = 9'(val);
   endtask

   task automatic row(input bit f, input int val);
      in_valid = 1'b1;
      in_first = f;
      set_all(val);
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic block(input int val);
      row(1'b1, val);
      for (int i = 1; i < 8; i++) row(1'b0, val);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_first = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clear_stats();
      n_pulse = 0; n_pd = 0; last_val = -1; last_lat = -1;
      first_val = -1; first_cyc = -1; last_cyc = -1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      set_all(0);
      clear_stats();
      idle(3);
      rst = 1'b0;
      check("reset_row_idx", 32'(row_idx), 0);
      check("reset_satd", 32'(satd), 0);
      check("reset_drain_busy", 32'(drain_busy), 0);

      // All +1: only the DC coefficient is nonzero, 64
      clear_stats();
      block(1);
      idle(10);
      check("ones_pulses", n_pulse, 1);
      check("ones_satd", last_val, 64);
      check("ones_latency", last_lat, 8);

      // +255 then -255, back to back
      clear_stats();
      block(255);
      block(-255);
      idle(10);
      check("pm255_pulses", n_pulse, 2);
      check("pm255_first", first_val, 16320);
      check("pm255_second", last_val, 16320);
      check("pm255_spacing", last_cyc - first_cyc, 8);

      // Single impulse: all 64 coefficients are +-1
      clear_stats();
      in_valid = 1'b1;
      in_first = 1'b1;
      set_all(0);
      d[0] = 9'sd1;
      tick();
      for (int i = 1; i < 8; i++) row(1'b0, 0);
      idle(10);
      check("impulse_satd", last_val, 64);

      // Partial block discarded by a fresh in_first
      clear_stats();
      row(1'b1, 5);
      row(1'b0, -3);
      row(1'b0, 7);
      block(1);
      idle(10);
      check("partial_drops", n_pd, 1);
      check("partial_pulses", n_pulse, 1);
      check("partial_satd", last_val, 64);
      check("partial_row_idx", 32'(row_idx), 0);

      // Gaps of 1-3 idle cycles inside the block
      clear_stats();
      row(1'b1, 1);
      for (int i = 1; i < 8; i++) begin
         idle(int'($urandom_range(1, 3)));
         row(1'b0, 1);
      end
      idle(10);
      check("gaps_satd", last_val, 64);
      check("gaps_latency", last_lat, 8);

      // Reset after four drain steps aborts the drain
      clear_stats();
      block(3);
      idle(4);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(12);
      check("abort_pulses", n_pulse, 0);
      check("abort_satd", 32'(satd), 0);
      check("abort_busy", 32'(drain_busy), 0);
      block(1);
      idle(10);
      check("after_abort_pulses", n_pulse, 1);
      check("after_abort_satd", last_val, 64);

      // Random traffic with occasional in_first and reset
      clear_stats();
      repeat (600) begin
         rst      = ($urandom_range(0, 299) == 0);
         in_valid = ($urandom_range(0, 9) < 8);
         in_first = ($urandom_range(0, 24) == 0);
         for (int j = 0; j < 8; j++) d[j] = 9'(int'($urandom_range(0, 510)) - 255);
         tick();
      end
      rst = 1'b0;
      idle(10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
